// File: rtl/fp_sum_tree.sv
// Purpose: reduces N_IN binary32 lanes to one sum through a balanced tree of registered float adders.
// Latency: LEVELS cycles from the cycle in_valid is accepted to the cycle out_valid is seen.
// Backpressure: the whole pipeline stalls while out_valid && !out_ready; in_ready mirrors that.
module fp_sum_tree #(
  parameter int N_IN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*N_IN-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_sum
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int NODES  = N_IN - 1;

  // Offset of the first node of level l in the flattened node arrays.
  function automatic int base(input int l);
    return N_IN - 2 * (N_IN >> l);
  endfunction

  // One tree node: truncating binary32 add with flushed denormals.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic               a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [31:0]        big, sml;
    logic [7:0]         ediff;
    logic [23:0]        ms_sh;
    logic [24:0]        msum;
    logic [4:0]         lz;
    logic [22:0]        frac;
    logic signed [9:0]  exp_r;
    logic [31:0]        res;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    // Full magnitude ordering so equal exponents still pick the larger mantissa.
    big   = (b[30:0] > a[30:0]) ? b : a;
    sml   = (b[30:0] > a[30:0]) ? a : b;
    ediff = big[30:23] - sml[30:23];
    ms_sh = (ediff >= 8'd25) ? 24'd0 : ({1'b1, sml[22:0]} >> ediff);
    if (big[31] == sml[31]) msum = {2'b01, big[22:0]} + {1'b0, ms_sh};
    else                    msum = {2'b01, big[22:0]} - {1'b0, ms_sh};
    // Priority encode the leading one; the highest set bit wins.
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (msum[i]) lz = 5'(23 - i);
    end
    if (msum[24]) begin
      frac  = msum[23:1];
      exp_r = $signed({2'b00, big[30:23]}) + 10'sd1;
    end else begin
      frac  = 23'(msum[22:0] << lz);
      exp_r = $signed({2'b00, big[30:23]}) - $signed({5'd0, lz});
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) res = 32'h7FC0_0000;
    else if (a_inf)                 res = a;
    else if (b_inf)                 res = b;
    else if (a_zero)                res = b_zero ? 32'h0 : b;
    else if (b_zero)                res = a;
    else if (msum == 25'd0)         res = 32'h0;
    else if (exp_r <= 10'sd0)       res = 32'h0;
    else if (exp_r >= 10'sd255)     res = {big[31], 8'hFF, 23'd0};
    else                            res = {big[31], exp_r[7:0], frac};
    return res;
  endfunction

  logic [31:0]       node_d [NODES];
  logic [31:0]       node_q [NODES];
  logic [NODES-1:0]  load;
  logic [LEVELS-1:0] vld_q;
  logic              advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[LEVELS-1];
  assign out_sum   = node_q[NODES-1];

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    for (genvar j = 0; j < (N_IN >> l); j++) begin : g_node
      if (l == 1) begin : g_leaf
        assign node_d[base(1) + j] = fadd(in_data[64*j +: 32], in_data[64*j+32 +: 32]);
        assign load[base(1) + j]   = in_valid;
      end else begin : g_inner
        assign node_d[base(l) + j] = fadd(node_q[base(l-1) + 2*j], node_q[base(l-1) + 2*j + 1]);
        assign load[base(l) + j]   = vld_q[l-2];
      end
    end
  end

  // Shift valid bits and capture partial sums; bubbles leave node data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NODES; i++) node_q[i] <= 32'h0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < LEVELS; k++) vld_q[k] <= vld_q[k-1];
      for (int i = 0; i < NODES; i++) begin
        if (load[i]) node_q[i] <= node_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fp_sum_tree.sv
module tb_fp_sum_tree;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data;
  logic [31:0]  out_sum;
  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [255:0] in_data8;
  logic [31:0]  out_sum8;

  always #5 clk = ~clk;

  fp_sum_tree #(.N_IN(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  fp_sum_tree #(.N_IN(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8)
  );

  typedef struct { logic [31:0] val; int due; } exp_t;
  exp_t q4[$];
  exp_t q8[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Present a vector until accepted; expected sum goes to the scoreboard.
  task automatic send4(input logic [127:0] d, input logic [31:0] e, input bit lat);
    int n = 0;
    int c;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send4_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
      return;
    end
    c = cyc;
    q4.push_back('{e, lat ? c + 2 : -1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [255:0] d, input logic [31:0] e);
    int n = 0;
    in_data8  = d;
    in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      chk("send8_timeout", 32'(n), 32'd0);
      in_valid8 = 1'b0;
      return;
    end
    q8.push_back('{e, cyc + 3});
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // Scoreboard monitor for the 4-lane instance, including stall stability.
  initial begin
    exp_t        e;
    bit          stalled = 1'b0;
    logic [31:0] held = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q4.size() == 0) begin
          chk("unexpected_out4", out_valid, 1'b0);
        end else begin
          e = q4.pop_front();
          chk("sum4", out_sum, e.val);
          if (e.due >= 0) chk("latency4", 32'(cyc), 32'(e.due));
        end
      end
      if (!rst && out_valid && !out_ready) begin
        if (stalled) chk("stall_hold4", out_sum, held);
        held    = out_sum;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Scoreboard monitor for the 8-lane instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          chk("unexpected_out8", out_valid8, 1'b0);
        end else begin
          e = q8.pop_front();
          chk("sum8", out_sum8, e.val);
          chk("latency8", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 20000", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_data8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic sum, single-cycle valid pulse
    send4(pack4(32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000), 32'h41900000, 1'b1);
    @(posedge clk);
    #1;
    chk("basic_valid_hi", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("basic_valid_lo", {31'd0, out_valid}, 32'd0);

    // Cancellation then mixed signs, back-to-back
    send4(pack4(32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000), 32'h00000000, 1'b1);
    send4(pack4(32'h3FC00000, 32'hBE800000, 32'h00000000, 32'h00000000), 32'h3FA00000, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four streamed vectors, output held off for three cycles
    fork
      begin
        send4(pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 32'h41200000, 1'b0);
        send4(pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 32'h40800000, 1'b0);
        send4(pack4(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), 32'h41000000, 1'b0);
        send4(pack4(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000), 32'h40000000, 1'b0);
      end
      begin
        n = 0;
        @(posedge clk);
        #1;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Specials
    send4(pack4(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000), 32'h7FC00000, 1'b1);
    send4(pack4(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000), 32'h7F800000, 1'b1);
    send4(pack4(32'h3F800000, 32'h40000000, 32'h7FC00001, 32'h00000000), 32'h7FC00000, 1'b1);
    // Denormal flush and alignment truncation
    send4(pack4(32'h00000001, 32'h40000000, 32'h00000000, 32'h00000000), 32'h40000000, 1'b1);
    send4(pack4(32'h4B800000, 32'h3F800000, 32'h00000000, 32'h00000000), 32'h4B800000, 1'b1);

    n = 0;
    while (q4.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;

    // Reset while a vector is in flight: nothing may come out afterwards
    in_data  = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", out_sum, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("postrst_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("postrst_sum", out_sum, 32'h0);

    // Eight-lane instance: 1.0 .. 8.0
    send8({32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
           32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h42100000);

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sum_tree.md
# fp_sum_tree

Pipelined, parametrised IEEE-754 single-precision summation tree. It reduces `N_IN` operand lanes to one sum through a balanced binary tree of registered two-input float adders, one pipeline stage per tree level. A valid/ready handshake with full-pipeline stall is included. The block replaces fixed four-input combinational float adders in the battery-telemetry datapath, such as cell-voltage and current summation.

## Interface
- `N_IN`, 4, number of operand lanes; power of two, 2..16.
- `LEVELS`, log2(`N_IN`), derived localparam; also the pipeline depth.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand vector `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts the vector when `in_valid && in_ready`.
- `in_data`  in  32*`N_IN`  lane k at bits [32k+31:32k], IEEE-754 binary32.
- `out_valid`  out  1  `out_sum` holds a result.
- `out_ready`  in  1  downstream accepts the result when `out_valid && out_ready`.
- `out_sum`  out  32  binary32 sum of the accepted vector.

## Operation
**Pipeline structure**
- Level L (1..`LEVELS`) holds `N_IN`/2^L registered partial sums plus one valid bit.
- Pairing is fixed: at level 1, lane 2j is added to lane 2j+1; each later level pairs its outputs the same way.
- Result order is therefore deterministic and bit-reproducible.

**Stall and handshake**
- `advance` = `!out_valid || out_ready`.
- `in_ready` = `advance`, combinational.
- All stages shift only when `advance` = 1; otherwise every stage holds, including bubbles.
- Stage valid bits propagate with the data; `in_valid && in_ready` loads level 1.
- `out_valid` and `out_sum` are the last-level registers.

**Two-input adder rules (each node)**
- Operand decode:
  - exp = 0: treated as zero. Denormals are flushed; the sign is ignored.
  - exp = 255, mantissa ≠ 0: NaN.
  - exp = 255, mantissa = 0: ±inf.
- Special results:
  - Any NaN input, or +inf + −inf → canonical NaN `0x7FC00000`.
  - Otherwise any inf → that inf.
- Ordering: the larger operand is chosen by the magnitude {exp, mantissa}, not exponent alone. The result sign is the larger operand's sign.
- Alignment:
  - Hidden-1 24-bit mantissas; the smaller one is shifted right by the exponent difference.
  - A difference ≥ 25 contributes 0.
  - Shifted-out bits are discarded; rounding is truncation toward zero.
- Add/subtract: add when signs match, else subtract smaller from larger. The 25-bit result carries into an exponent increment with a 1-bit right shift.
- Normalisation: a leading-zero count with a single barrel left shift. No iterative loop is allowed.
- Result exceptions:
  - Zero mantissa result → `0x00000000` (+0).
  - Exponent after normalisation ≤ 0 → +0.
  - Exponent ≥ 255 → ±inf (`0x7F800000` / `0xFF800000`).
- Zero operand: if one operand is zero, the result is the other operand bit-exactly, with a denormal flushed to +0.

## Timing
- **Latency:** a vector accepted at edge t gives `out_valid` = 1 after edge t+`LEVELS` if no stall occurs. For `N_IN`=4, latency is 2.
- **Throughput:** one vector per cycle while `out_ready` = 1.
- **Stall:** results are never dropped or duplicated.
  - A stalled `out_sum` stays stable until accepted.
  - A vector presented while `in_ready` = 0 is not captured.
- **Simultaneous events:** output accept and input accept in the same cycle are both legal, giving full throughput.
- **Reset values:**
  - All stage valid bits, `out_valid` = 0.
  - All data registers, `out_sum` = `0x00000000`.
  - `in_ready` = 1 after reset.
- **Reset mid-operation:** asserting `rst` discards all in-flight vectors immediately (asynchronous). No result appears for them after release.
- **Combinational depth:** one float add per stage, so the critical path is one node.

## Test plan
- **Basic sum:** `N_IN`=4, lanes {3.0, 4.0, 5.0, 6.0} = {`40400000`,`40800000`,`40A00000`,`40C00000`}, one-cycle `in_valid`, `out_ready`=1 → `out_valid` exactly 2 cycles later, `out_sum` = `41900000` (18.0), high for one cycle.
- **Cancellation and mixed signs:** {1.0, −1.0, 2.0, −2.0} → `00000000`. Then {1.5, −0.25, 0, 0} → `3FA00000` (1.25). Sent back-to-back; results appear on consecutive cycles in order.
- **Backpressure:** stream 4 vectors with `in_valid`=1 and hold `out_ready`=0 for 3 cycles after the first `out_valid`.
  - `in_ready` drops the same cycle `out_valid`=1 with `out_ready`=0.
  - All 4 sums emerge in order with no loss or duplication.
  - `out_sum` is stable while stalled.
- **Specials:**
  - {`7F800000`, `FF800000`, 1.0, 1.0} → `7FC00000`.
  - {`7F7FFFFF`, `7F7FFFFF`, 0, 0} → `7F800000`.
  - Any lane `7FC00001` → `7FC00000`.
- **Denormal and alignment:** {`00000001`, 2.0, 0, 0} → `40000000`. {2^24 = `4B800000`, 1.0, 0, 0} → `4B800000` (truncated).
- **Reset and width:**
  - Assert `rst` one cycle after accepting a vector → `out_valid` stays 0 and `out_sum` = 0.
  - Repeat the basic sum with `N_IN`=8 (lanes 1.0..8.0) → `42100000` (36.0) after 3 cycles.
